// File: rtl/instruction_decode.sv
// ID stage of the 5-stage MIPS pipeline: decodes the supported subset, reads the
// 32-entry register file (with write-through bypass from writeback), detects
// load-use hazards and registers everything into the ID/EX pipeline register.
module instruction_decode #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr,
  input  logic [31:0]       pc_in,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [31:0]       imm_ext,
  output logic [REG_AW-1:0] rs_addr,
  output logic [REG_AW-1:0] rt_addr,
  output logic [REG_AW-1:0] dest_addr,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              branch,
  output logic              jump,
  output logic              alu_src,
  output logic              mem_to_reg,
  output logic [3:0]        alu_op,
  output logic [31:0]       jump_target,
  output logic [31:0]       pc_out,
  output logic              illegal
);

  localparam int NREG = 1 << REG_AW;
  localparam logic [REG_AW-1:0] ZERO_ADDR = {REG_AW{1'b0}};
  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

  logic [DATA_W-1:0] r_regs [NREG];

  logic [5:0]        w_opcode;
  logic [5:0]        w_funct;
  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  logic [REG_AW-1:0] w_rd;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;

  logic              w_reg_write;
  logic              w_mem_read;
  logic              w_mem_write;
  logic              w_branch;
  logic              w_jump;
  logic              w_alu_src;
  logic              w_mem_to_reg;
  logic [3:0]        w_alu_op;
  logic [REG_AW-1:0] w_dest;
  logic              w_illegal;
  logic              w_uses_rt;
  logic              w_hazard;
  logic              w_bubble;

  assign w_opcode = instr[31:26];
  assign w_funct  = instr[5:0];
  assign w_rs     = instr[25:21];
  assign w_rt     = instr[20:16];
  assign w_rd     = instr[15:11];

  // Register 0 reads as zero; a same-cycle writeback to the read address is bypassed
  assign w_rs_val = (w_rs == ZERO_ADDR) ? ZERO_DATA :
                    (wb_en && (wb_addr == w_rs)) ? wb_data : r_regs[w_rs];
  assign w_rt_val = (w_rt == ZERO_ADDR) ? ZERO_DATA :
                    (wb_en && (wb_addr == w_rt)) ? wb_data : r_regs[w_rt];

  // The previous instruction is a load whose target feeds this one: hold fetch a cycle
  assign w_hazard = mem_read && (rt_addr != ZERO_ADDR) &&
                    ((rt_addr == w_rs) || (w_uses_rt && (rt_addr == w_rt)));
  assign stall    = w_hazard && !flush;
  assign w_bubble = flush || w_hazard;

  // Register file write port; writes to register 0 are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= ZERO_DATA;
      end
    end else if (wb_en && (wb_addr != ZERO_ADDR)) begin
      r_regs[wb_addr] <= wb_data;
    end else begin
      r_regs <= r_regs;
    end
  end

  // Opcode/funct decode into control signals and destination register
  always_comb begin
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_alu_src    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_op     = 4'd0;
    w_dest       = ZERO_ADDR;
    w_illegal    = 1'b0;
    w_uses_rt    = 1'b0;
    case (w_opcode)
      6'h00: begin
        w_uses_rt = 1'b1;
        case (w_funct)
          6'h20:   w_alu_op = 4'd0;
          6'h22:   w_alu_op = 4'd1;
          6'h24:   w_alu_op = 4'd2;
          6'h25:   w_alu_op = 4'd3;
          6'h2A:   w_alu_op = 4'd4;
          default: w_illegal = 1'b1;
        endcase
        w_reg_write = ~w_illegal;
        w_dest      = w_illegal ? ZERO_ADDR : w_rd;
      end
      6'h23: begin
        w_reg_write  = 1'b1;
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
        w_alu_src    = 1'b1;
        w_dest       = w_rt;
      end
      6'h2B: begin
        w_uses_rt   = 1'b1;
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
      end
      6'h04: begin
        w_uses_rt = 1'b1;
        w_branch  = 1'b1;
        w_alu_op  = 4'd1;
      end
      6'h08: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_dest      = w_rt;
      end
      6'h02: begin
        w_jump = 1'b1;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  // ID/EX pipeline register; flush or a load-use hazard inserts an all-zero bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || w_bubble) begin
      rs_data     <= ZERO_DATA;
      rt_data     <= ZERO_DATA;
      imm_ext     <= 32'h0000_0000;
      rs_addr     <= ZERO_ADDR;
      rt_addr     <= ZERO_ADDR;
      dest_addr   <= ZERO_ADDR;
      reg_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      branch      <= 1'b0;
      jump        <= 1'b0;
      alu_src     <= 1'b0;
      mem_to_reg  <= 1'b0;
      alu_op      <= 4'd0;
      jump_target <= 32'h0000_0000;
      pc_out      <= 32'h0000_0000;
      illegal     <= 1'b0;
    end else begin
      rs_data     <= w_rs_val;
      rt_data     <= w_rt_val;
      imm_ext     <= {{16{instr[15]}}, instr[15:0]};
      rs_addr     <= w_rs;
      rt_addr     <= w_rt;
      dest_addr   <= w_dest;
      reg_write   <= w_reg_write;
      mem_read    <= w_mem_read;
      mem_write   <= w_mem_write;
      branch      <= w_branch;
      jump        <= w_jump;
      alu_src     <= w_alu_src;
      mem_to_reg  <= w_mem_to_reg;
      alu_op      <= w_alu_op;
      jump_target <= {pc_in[31:28], instr[25:0], 2'b00};
      pc_out      <= pc_in;
      illegal     <= w_illegal;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed-vector bench for instruction_decode with hand-computed expectations.
module tb_instruction_decode;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic [31:0] pc_in;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm_ext;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  dest_addr;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic        jump;
  logic        alu_src;
  logic        mem_to_reg;
  logic [3:0]  alu_op;
  logic [31:0] jump_target;
  logic [31:0] pc_out;
  logic        illegal;

  int n_cmp;
  int n_err;

  instruction_decode #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .pc_in(pc_in), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall),
    .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .dest_addr(dest_addr),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jump(jump), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
    .alu_op(alu_op), .jump_target(jump_target), .pc_out(pc_out), .illegal(illegal)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // All control bits packed for compact comparison:
  // {reg_write, mem_read, mem_write, branch, jump, alu_src, mem_to_reg, illegal}
  function automatic logic [31:0] ctl();
    return {24'd0, reg_write, mem_read, mem_write, branch, jump, alu_src, mem_to_reg, illegal};
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctl"}, ctl(), 32'h0);
    check_eq({tag, "_rs_data"}, rs_data, 32'h0);
    check_eq({tag, "_rt_data"}, rt_data, 32'h0);
    check_eq({tag, "_imm"}, imm_ext, 32'h0);
    check_eq({tag, "_dest"}, {27'd0, dest_addr}, 32'h0);
    check_eq({tag, "_pc_out"}, pc_out, 32'h0);
    check_eq({tag, "_jt"}, jump_target, 32'h0);
    check_eq({tag, "_alu_op"}, {28'd0, alu_op}, 32'h0);
    check_eq({tag, "_stall"}, {31'd0, stall}, 32'h0);
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    instr   = 32'h0000_0000;
    pc_in   = 32'h0000_0000;
    flush   = 1'b0;
    wb_en   = 1'b0;
    wb_addr = 5'd0;
    wb_data = 32'h0;

    #12;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Fill registers 1..31 with 0x100+i
    wb_en = 1'b1;
    for (int i = 1; i < 32; i++) begin
      wb_addr = 5'(i);
      wb_data = 32'h100 + 32'(i);
      tick();
    end
    wb_en = 1'b0;

    // add $3,$1,$2
    instr = 32'h0022_1820;
    pc_in = 32'h0000_0010;
    tick();
    check_eq("add_rs", rs_data, 32'h101);
    check_eq("add_rt", rt_data, 32'h102);
    check_eq("add_dest", {27'd0, dest_addr}, 32'd3);
    check_eq("add_ctl", ctl(), 32'h80);
    check_eq("add_aluop", {28'd0, alu_op}, 32'd0);
    check_eq("add_pc", pc_out, 32'h10);

    // Write to reg 0 is ignored; rs=0 reads 0
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
    instr = 32'h0002_1820;
    tick();
    check_eq("r0_rd_wb", rs_data, 32'h0);
    wb_en = 1'b0;
    tick();
    check_eq("r0_rd_after", rs_data, 32'h0);

    // Same-cycle bypass: reg 5 <= 0x55 while decoding rs=5
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h55;
    instr = 32'h00A2_1820;
    tick();
    check_eq("bypass_rs", rs_data, 32'h55);
    wb_en = 1'b0;
    tick();
    check_eq("written_rs", rs_data, 32'h55);

    // lw $4,8($1) then add $5,$4,$2 -> one-cycle stall
    instr = 32'h8C24_0008;
    tick();
    check_eq("lw_ctl", ctl(), 32'hC6);
    check_eq("lw_dest", {27'd0, dest_addr}, 32'd4);
    check_eq("lw_imm", imm_ext, 32'h8);
    check_eq("lw_rs", rs_data, 32'h101);
    instr = 32'h0082_2820;
    #1;
    check_eq("hz_stall", {31'd0, stall}, 32'd1);
    tick();
    check_eq("hz_bubble_ctl", ctl(), 32'h0);
    check_eq("hz_stall_drop", {31'd0, stall}, 32'd0);
    tick();
    check_eq("hz_add_rs_addr", {27'd0, rs_addr}, 32'd4);
    check_eq("hz_add_ctl", ctl(), 32'h80);
    check_eq("hz_add_dest", {27'd0, dest_addr}, 32'd5);
    check_eq("hz_add_rs", rs_data, 32'h104);

    // lw then addi $6,$7,-1 -> no dependency, no stall
    instr = 32'h8C24_0008;
    tick();
    instr = 32'h20E6_FFFF;
    #1;
    check_eq("addi_nostall", {31'd0, stall}, 32'd0);
    tick();
    check_eq("addi_imm", imm_ext, 32'hFFFF_FFFF);
    check_eq("addi_dest", {27'd0, dest_addr}, 32'd6);
    check_eq("addi_ctl", ctl(), 32'h84);
    check_eq("addi_rs", rs_data, 32'h107);

    // lw then sw $4,0($1) (rt dependency) with flush in the hazard cycle
    instr = 32'h8C24_0008;
    tick();
    instr = 32'hAC24_0000;
    #1;
    check_eq("sw_rt_stall", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    #1;
    check_eq("flush_stall", {31'd0, stall}, 32'd0);
    tick();
    check_eq("flush_bubble", ctl(), 32'h0);
    flush = 1'b0;
    tick();
    check_eq("sw_ctl", ctl(), 32'h24);
    check_eq("sw_rt_data", rt_data, 32'h104);

    // j 0x10 from pc 0x40000000
    instr = 32'h0800_0010;
    pc_in = 32'h4000_0000;
    tick();
    check_eq("j_ctl", ctl(), 32'h08);
    check_eq("j_target", jump_target, 32'h4000_0040);
    check_eq("j_pc", pc_out, 32'h4000_0000);

    // beq $1,$2,3
    instr = 32'h1022_0003;
    tick();
    check_eq("beq_ctl", ctl(), 32'h10);
    check_eq("beq_aluop", {28'd0, alu_op}, 32'd1);
    check_eq("beq_rt", rt_data, 32'h102);

    // Remaining R-type ALU selects
    instr = 32'h0022_1822; tick(); check_eq("sub_aluop", {28'd0, alu_op}, 32'd1);
    instr = 32'h0022_1824; tick(); check_eq("and_aluop", {28'd0, alu_op}, 32'd2);
    instr = 32'h0022_1825; tick(); check_eq("or_aluop",  {28'd0, alu_op}, 32'd3);
    instr = 32'h0022_182A; tick(); check_eq("slt_aluop", {28'd0, alu_op}, 32'd4);

    // Illegal opcode and illegal funct
    instr = 32'hFC00_0000; tick();
    check_eq("ill_op_ctl", ctl(), 32'h01);
    instr = 32'h0022_1821; tick();
    check_eq("ill_fn_ctl", ctl(), 32'h01);
    check_eq("ill_fn_dest", {27'd0, dest_addr}, 32'd0);

    // Reset mid-stream clears outputs and register file immediately
    instr = 32'h0022_1820;
    pc_in = 32'h0000_0020;
    tick();
    check_eq("pre_rst_rs", rs_data, 32'h101);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    #3;
    rst_n = 1'b1;
    tick();
    check_eq("postrst_rs", rs_data, 32'h0);
    check_eq("postrst_rt", rt_data, 32'h0);
    check_eq("postrst_ctl", ctl(), 32'h80);
    check_eq("postrst_pc", pc_out, 32'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- ID stage of the 5-stage MIPS pipeline, directly downstream of instruction_fetch.
- Consumes the fetched instruction word and its PC; decodes the supported subset; reads the 32x32 register file.
- Registers all results into the ID/EX pipeline register.
- Detects load-use hazards and drives the fetch stage's stall input.
- The register file write port is driven by writeback.

Parameters:
DATA_W, 32, datapath and register width
REG_AW, 5, register address width (2**REG_AW registers)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
instr  input  32  instruction word from fetch
pc_in  input  32  PC of instr (fetch pc_out)
flush  input  1  squash the instruction in decode (taken branch/jump resolved downstream)
wb_en  input  1  register file write enable
wb_addr  input  REG_AW  register file write address
wb_data  input  DATA_W  register file write data
stall  output  1  combinational; high = fetch must hold PC and instr
rs_data  output  DATA_W  registered rs read value
rt_data  output  DATA_W  registered rt read value
imm_ext  output  32  registered sign-extended instr[15:0]
rs_addr  output  REG_AW  registered instr[25:21]
rt_addr  output  REG_AW  registered instr[20:16]
dest_addr  output  REG_AW  registered write destination
reg_write, mem_read, mem_write, branch, jump, alu_src, mem_to_reg  output  1 each  registered control
alu_op  output  4  registered ALU select
jump_target  output  32  registered {pc_in[31:28], instr[25:0], 2'b00}
pc_out  output  32  registered pc_in
illegal  output  1  registered; unsupported opcode/funct

Behaviour:
- Reset (async, rst_n=0): all registered outputs 0. All 32 registers cleared to 0. stall=0 while in reset.
- Register file:
  - Write on rising edge when wb_en=1 and wb_addr!=0.
  - Register 0 always reads 0.
  - Reads are combinational. If wb_en=1 and wb_addr equals the nonzero read address, wb_data is bypassed to the read (write-through, same cycle).
- Decode, by opcode instr[31:26]:
  - 0x00 R-type, funct instr[5:0]:
    - 0x20 ADD (alu_op=0), 0x22 SUB (1), 0x24 AND (2), 0x25 OR (3), 0x2A SLT (4).
    - reg_write=1, dest=rd (instr[15:11]), alu_src=0.
  - 0x23 LW: reg_write=1, mem_read=1, mem_to_reg=1, alu_src=1, alu_op=0, dest=rt.
  - 0x2B SW: mem_write=1, alu_src=1, alu_op=0.
  - 0x04 BEQ: branch=1, alu_op=1, alu_src=0.
  - 0x08 ADDI: reg_write=1, alu_src=1, alu_op=0, dest=rt.
  - 0x02 J: jump=1.
  - Any other opcode or R-type funct: illegal=1, all controls 0.
- Latency: one cycle. Decode result appears at outputs on the edge after instr is presented.
- Load-use hazard:
  - Condition: registered mem_read=1 and registered rt_addr!=0, and rt_addr equals current instr rs, or equals current instr rt when the current instruction reads rt (R-type, SW, BEQ).
  - On hazard: stall=1 in the same cycle. On the next edge a bubble is registered: all control and illegal = 0, datapath fields don't-care but driven 0.
  - The following cycle re-decodes the held instr. mem_read is now 0, so stall deasserts; hazard stall is exactly one cycle.
- Flush:
  - flush=1 at an edge registers a bubble regardless of instr.
  - flush has priority over stall: stall is forced to 0 while flush=1.
- Register 0 destinations: reg_write still asserted; the write is suppressed at the register file.
- Reset mid-operation: immediate clear of all state. The first post-reset edge decodes whatever instr is present.

Test Plan:
- Reset, release, wb_en=1 writing reg i with 0x100+i for i=1..31 -> instr 0x00221820 (add $3,$1,$2) gives rs_data=0x101, rt_data=0x102, dest_addr=3, reg_write=1, alu_op=0 one cycle later.
- wb_en=1, wb_addr=0, wb_data=0xDEADBEEF, then decode rs=0 -> rs_data=0. Same-cycle wb to reg 5 = 0x55 while decoding rs=5 -> rs_data=0x55 (bypass).
- lw $4,8($1) (0x8C240008) followed by add $5,$4,$2 -> stall=1 for exactly one cycle; bubble (reg_write=0, mem_read=0); then add decoded with rs_addr=4, mem_read=0.
- lw $4,8($1) followed by addi $6,$7,-1 (0x20E6FFFF) -> no stall; imm_ext=0xFFFFFFFF, dest_addr=6, alu_src=1.
- j 0x0000010 with pc_in=0x40000000 -> jump=1, jump_target=0x40000040. flush=1 during a hazard cycle -> stall=0, bubble registered.
- instr 0xFC000000 -> illegal=1, all controls 0. Assert rst_n=0 mid-stream -> all outputs and registers 0 immediately.
